// File: rtl/rev_alu_result_stage.sv
// ALU result stage: selects one of P/Q/R/P^Q, queues it with its opcode, and derives flags from the head.
// One-cycle latency into an empty queue; in_ready = !full, and out_ready never reaches in_ready combinationally.

module rev_alu_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_dat     = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module rev_alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH-1:0] in_q,
    input  logic [WIDTH-1:0] in_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_parity,
    output logic [CNT_W-1:0] result_count
);
    logic [WIDTH-1:0]   w_sel;
    logic [WIDTH+1:0]   w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   r_result_count;

    always_comb begin
        w_sel = in_p;
        case (in_op)
            2'b00:   w_sel = in_p;
            2'b01:   w_sel = in_q;
            2'b10:   w_sel = in_r;
            default: w_sel = in_p ^ in_q;
        endcase
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    rev_alu_fifo #(
        .W     (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_dat   ({in_op, w_sel}),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Flags come from the registered head, so an empty queue shows all-zero outputs.
    assign out_result = w_empty ? '0 : w_head[WIDTH-1:0];
    assign out_op     = w_empty ? 2'b00 : w_head[WIDTH+1:WIDTH];
    assign out_zero   = out_valid && (out_result == '0);
    assign out_neg    = out_result[WIDTH-1];
    assign out_parity = ^out_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_count <= '0;
        end else if (w_pop) begin
            r_result_count <= r_result_count + CNT_W'(1);
        end
    end

    assign result_count = r_result_count;
endmodule
